mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one mux-selected datapath resource between NUM_REQ requesters.
- Drives the select input of the 2:1 mux (or a mux tree when NUM_REQ > 2) and returns a one-hot grant to each requester.
- Inserts a one-cycle dead bubble between owners so the mux never switches while a grant is live.
- Sits between requester logic and the shared mux in the project top level.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- MAX_HOLD, 8, max cycles one owner may hold the grant while others wait (timeout feature only); legal range ≥2.
- SEL_W, $clog2(NUM_REQ), select width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  NUM_REQ  level request per requester; held high for the whole transaction.
- grant  output  NUM_REQ  one-hot (or zero) grant, registered.
- sel  output  SEL_W  binary index of current/last owner; drives mux sel.
- busy  output  1  high while any grant is asserted.
- expire  output  1  one-cycle pulse when a grant is forcibly revoked; tied 0 without the macro.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - grant = 0, sel = 0, busy = 0, expire = 0.
  - State = IDLE, hold_cnt = 0.
  - Priority pointer last = NUM_REQ-1, so req[0] has highest priority after reset.
  - Assertion of rst mid-grant clears grant immediately, without waiting for clk.
- States: IDLE, GRANT.
- IDLE:
  - If req ≠ 0, pick the first set bit searching upward from last+1 (mod NUM_REQ).
  - Next edge: grant = onehot(pick), sel = pick, busy = 1, last = pick, state → GRANT.
  - Latency is req-sampled to grant = 1 cycle.
  - If req = 0: stay in IDLE; sel holds its last value and does not toggle.
- GRANT:
  - Hold while req[owner] = 1. Requests from others are ignored (they wait).
  - When req[owner] samples 0: next edge grant = 0, busy = 0, state → IDLE. sel is unchanged.
  - The new owner is granted on the edge after that, giving a minimum one-cycle bubble between owners.
- Simultaneous requests: round-robin order. Two requesters both held high alternate grants; neither starves.
- Owner drops and another requester raises req in the same cycle: the bubble still applies, and the new requester is granted 2 edges later.
- Grant is never asserted to a requester whose req was low at the sampling edge.
- The owner re-raising req during the bubble competes normally. It is lowest priority because last = owner.
- Invariants: $onehot0(grant); busy == |grant; sel changes only on the edge that asserts a new grant.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Enabled:
  - hold_cnt increments each GRANT cycle, starting at 0 on the grant edge.
  - If hold_cnt == MAX_HOLD-1 and any other req bit is high, the next edge forces grant = 0, expire = 1 for one cycle, and state → IDLE.
  - The revoked owner is then lowest priority.
  - If no other requester is waiting, hold_cnt saturates at MAX_HOLD-1 and no revoke occurs.
  - hold_cnt clears on entry to IDLE.
- Disabled: no counter is built, expire is tied to 0, and the grant is held until the owner releases.

Decomposition:
- Package mux_arb_pkg holds:
  - the state enum type (IDLE, GRANT);
  - a localparam function computing SEL_W;
  - the onehot-from-index helper function.
- Sub-module rr_pick: combinational, purely combinational round-robin picker.
  - Inputs: req, last.
  - Outputs: pick index and valid.
  - Instantiated once.

Test Plan:
- rst high then released, req = 2'b00 for 5 cycles → grant = 0, sel = 0, busy = 0 throughout.
- req = 2'b01 at cycle 0, held 4 cycles, then dropped → grant = 01 at edge 1; sel = 0; grant = 00 on the edge after req drops; sel stays 0.
- req = 2'b11 held constantly, each owner dropping its req for one cycle after 3 cycles granted → grant sequence 01, 00, 10, 00, 01 …; sel alternates 0/1 only on grant edges.
- With MUX_ARB_TIMEOUT_EN and MAX_HOLD = 4:
  - req[0] held forever, req[1] raised at cycle 2 → grant[0] revoked after 4 cycles with expire = 1 pulse, and grant = 10 one bubble later.
  - req[1] never raised → grant[0] held indefinitely with no expire.
- rst asserted asynchronously between edges while grant = 10 → grant = 0 and busy = 0 before the next clk edge. After release with req = 11, req[0] is granted first.
- Random req stimulus for 10k cycles → $onehot0(grant) holds; no grant without req; every requester held high is granted within NUM_REQ × (max hold + 1) cycles.

Source files
------------

// File: rtl/mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter (package mux_arb_pkg).
// Holds the FSM state type, the select-width function and the one-hot helper.
package mux_arb_pkg;

   localparam int MAX_REQ = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Width of a binary index for n items; never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [MAX_REQ-1:0] onehot(input int idx);
      return MAX_REQ'(1) << idx;
   endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker: selects the first set req bit at or after last+1,
// wrapping modulo NUM_REQ. valid is low when no request is pending.
module rr_pick
   import mux_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int SEL_W   = sel_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   last,
   output logic [SEL_W-1:0]   pick,
   output logic               valid
);

   always_comb begin
      int w_best;
      int w_dist;
      // NOTE: every output and temporary gets a default first, so no latch can be inferred.
      pick   = '0;
      valid  = 1'b0;
      w_best = NUM_REQ;
      w_dist = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // Distance of requester i from last+1 going upward with wrap.
         w_dist = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
         if (req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            pick   = SEL_W'(i);
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner arbiter for a shared mux, with a one-cycle bubble between owners.
// Define MUX_ARB_TIMEOUT_EN to revoke an owner after MAX_HOLD cycles while others wait.
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter  int NUM_REQ  = 2,
   parameter  int MAX_HOLD = 8,
   localparam int SEL_W    = sel_width(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [SEL_W-1:0]   sel,
   output logic               busy,
   output logic               expire
);

   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || MAX_HOLD < 2) begin : g_param_check
      $error("mux_arbiter: NUM_REQ must be 2..8 and MAX_HOLD at least 2");
   end

   state_t             r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [SEL_W-1:0]   r_sel;
   logic [SEL_W-1:0]   r_last;
   logic [SEL_W-1:0]   w_pick;
   logic               w_valid;
   logic               w_owner_req;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .req   (req),
      .last  (r_last),
      .pick  (w_pick),
      .valid (w_valid)
   );

   assign w_owner_req = |(req & r_grant);

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int HOLD_W = sel_width(MAX_HOLD);

   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_expire;
   logic              w_others;
   logic              w_hold_max;

   assign w_others   = |(req & ~r_grant);
   assign w_hold_max = (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));
`endif

   // NOTE: state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_sel   <= '0;
         r_last  <= SEL_W'(NUM_REQ - 1);
`ifdef MUX_ARB_TIMEOUT_EN
         r_hold_cnt <= '0;
         r_expire   <= 1'b0;
`endif
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
         r_expire <= 1'b0;
`endif
         unique case (r_state)
            IDLE: begin
               if (w_valid) begin
                  r_state <= GRANT;
                  r_grant <= NUM_REQ'(onehot(int'(w_pick)));
                  r_sel   <= w_pick;
                  r_last  <= w_pick;
               end
            end
            GRANT: begin
               // Dropping to IDLE first is what creates the bubble; sel stays put meanwhile.
               if (!w_owner_req) begin
                  r_state <= IDLE;
                  r_grant <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
                  r_hold_cnt <= '0;
               end else if (w_hold_max && w_others) begin
                  r_state    <= IDLE;
                  r_grant    <= '0;
                  r_hold_cnt <= '0;
                  r_expire   <= 1'b1;
               end else if (!w_hold_max) begin
                  r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
`endif
               end
            end
         endcase
      end
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign busy  = |r_grant;
`ifdef MUX_ARB_TIMEOUT_EN
   assign expire = r_expire;
`else
   assign expire = 1'b0;
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus a randomized run checked
// against a cycle-level behavioural model; timeout scenarios follow MUX_ARB_TIMEOUT_EN.
module tb_mux_arbiter;

   localparam int N    = 2;
   localparam int HOLD = 4;
   localparam int SW   = 1;
   localparam int LMAX = 5;
   localparam int WAIT_BOUND = N * (LMAX + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N-1:0]  grant;
   logic [SW-1:0] sel;
   logic          busy;
   logic          expire;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: owner index (-1 = none), last winner, cycles held so far.
   int m_owner;
   int m_last;
   int m_sel;
   int m_held;
   bit m_expire;

   always #5 clk = ~clk;

   mux_arbiter #(
      .NUM_REQ  (N),
      .MAX_HOLD (HOLD)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req    (req),
      .grant  (grant),
      .sel    (sel),
      .busy   (busy),
      .expire (expire)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog expired");
   end

   task automatic model_reset();
      m_owner  = -1;
      m_last   = N - 1;
      m_sel    = 0;
      m_held   = 0;
      m_expire = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] r);
      bit found;
      m_expire = 1'b0;
      if (m_owner < 0) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && r[(m_last + k) % N]) begin
               found   = 1'b1;
               m_owner = (m_last + k) % N;
            end
         end
         if (found) begin
            m_last = m_owner;
            m_sel  = m_owner;
            m_held = 1;
         end
      end else if (!r[m_owner]) begin
         m_owner = -1;
`ifdef MUX_ARB_TIMEOUT_EN
      end else if (m_held >= HOLD && (r & ~(N'(1) << m_owner)) != '0) begin
         m_owner  = -1;
         m_expire = 1'b1;
`endif
      end else begin
         m_held++;
      end
   endtask

   function automatic logic [N-1:0] model_grant();
      return (m_owner < 0) ? '0 : (N'(1) << m_owner);
   endfunction

   // One clock edge: the model sees the same req the DUT sampled; outputs settle by #1.
   task automatic step();
      @(posedge clk);
      model_step(req);
      #1;
   endtask

   task automatic apply_reset();
      req = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      req = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({grant, sel, busy, expire} !== '0) begin
         n_errors++;
         $display("FAIL reset_active: got grant=%b sel=%0d busy=%b expire=%b, expected all 0",
                  grant, sel, busy, expire);
      end
      #1;
      rst = 1'b0;
      model_reset();
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if ({grant, sel, busy, expire} !== '0) begin
            n_errors++;
            $display("FAIL reset_idle[%0d]: got grant=%b sel=%0d busy=%b expire=%b, expected all 0",
                     i, grant, sel, busy, expire);
         end
      end
   endtask

   task automatic test_single();
      apply_reset();
      req = 2'b01;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (grant !== 2'b01 || sel !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_hold[%0d]: got grant=%b sel=%0d busy=%b, expected 01/0/1",
                     i, grant, sel, busy);
         end
      end
      req = 2'b00;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if (grant !== 2'b00 || sel !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_release[%0d]: got grant=%b sel=%0d busy=%b, expected 00/0/0",
                     i, grant, sel, busy);
         end
      end
   endtask

   task automatic test_alternate();
      logic [N-1:0]  exp_g [13] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10,
                                    2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      logic [SW-1:0] exp_s [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
      apply_reset();
      for (int i = 0; i < 13; i++) begin
         case (i)
            3, 11:   req = 2'b10;
            7:       req = 2'b01;
            default: req = 2'b11;
         endcase
         step();
         n_checks++;
         if (grant !== exp_g[i] || sel !== exp_s[i] || busy !== |exp_g[i]) begin
            n_errors++;
            $display("FAIL alternate[%0d]: got grant=%b sel=%0d busy=%b, expected %b/%0d/%b",
                     i, grant, sel, busy, exp_g[i], exp_s[i], |exp_g[i]);
         end
      end
   endtask

   task automatic test_handover();
      logic [N-1:0] exp_g [3] = '{2'b01, 2'b00, 2'b10};
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         req = (i == 0) ? 2'b01 : 2'b10;
         step();
         n_checks++;
         if (grant !== exp_g[i] || sel !== ((i == 2) ? 1'b1 : 1'b0)) begin
            n_errors++;
            $display("FAIL handover[%0d]: got grant=%b sel=%0d, expected grant=%b", i, grant, sel, exp_g[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      apply_reset();
      req = 2'b10;
      step();
      n_checks++;
      if (grant !== 2'b10 || sel !== 1'b1) begin
         n_errors++;
         $display("FAIL async_setup: got grant=%b sel=%0d, expected 10/1", grant, sel);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
         n_errors++;
         $display("FAIL async_clear: got grant=%b busy=%b before next edge, expected 00/0", grant, busy);
      end
      req = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      step();
      n_checks++;
      if (grant !== 2'b01 || sel !== 1'b0) begin
         n_errors++;
         $display("FAIL async_restart: got grant=%b sel=%0d, expected 01/0", grant, sel);
      end
   endtask

   task automatic test_hold_no_waiter();
      apply_reset();
      req = 2'b01;
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if (grant !== 2'b01 || expire !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_alone[%0d]: got grant=%b expire=%b, expected 01/0", i, grant, expire);
         end
      end
   endtask

`ifdef MUX_ARB_TIMEOUT_EN
   task automatic test_timeout();
      logic [N-1:0] exp_g [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
      logic         exp_e [6] = '{0, 0, 0, 0, 1, 0};
      apply_reset();
      req = 2'b01;
      for (int i = 0; i < 6; i++) begin
         step();
         if (i == 1) req = 2'b11;
         n_checks++;
         if (grant !== exp_g[i] || expire !== exp_e[i]) begin
            n_errors++;
            $display("FAIL timeout[%0d]: got grant=%b expire=%b, expected %b/%b",
                     i, grant, expire, exp_g[i], exp_e[i]);
         end
      end
   endtask
`else
   task automatic test_hold_contended();
      apply_reset();
      req = 2'b11;
      for (int i = 0; i < 20; i++) begin
         step();
         n_checks++;
         if (grant !== 2'b01 || expire !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_contended[%0d]: got grant=%b expire=%b, expected 01/0", i, grant, expire);
         end
      end
   endtask
`endif

   task automatic test_random();
      int           len [N];
      int           wait_cnt [N];
      int           max_wait [N];
      logic [N-1:0] r_now;
      logic [N-1:0] nreq;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         len[i]      = 0;
         wait_cnt[i] = 0;
         max_wait[i] = 0;
      end
      for (int c = 0; c < 10000; c++) begin
         r_now = req;
         step();
         n_checks++;
         if (grant !== model_grant() || sel !== SW'(m_sel) ||
             busy !== (m_owner >= 0) || expire !== m_expire) begin
            n_errors++;
            $display("FAIL random_model[%0d]: got grant=%b sel=%0d busy=%b expire=%b, expected %b/%0d/%b/%b",
                     c, grant, sel, busy, expire, model_grant(), m_sel, m_owner >= 0, m_expire);
         end
         n_checks++;
         if (!$onehot0(grant) || (grant & ~r_now) != '0) begin
            n_errors++;
            $display("FAIL random_invariant[%0d]: got grant=%b with sampled req=%b", c, grant, r_now);
         end
         nreq = req;
         for (int i = 0; i < N; i++) begin
            if (req[i] && !grant[i]) wait_cnt[i]++;
            else                     wait_cnt[i] = 0;
            if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
            if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  nreq[i] = 1'b1;
                  len[i]  = $urandom_range(1, LMAX);
               end
            end else if (m_owner == i) begin
               len[i]--;
               if (len[i] <= 0) nreq[i] = 1'b0;
            end
         end
         req = nreq;
      end
      for (int i = 0; i < N; i++) begin
         n_checks++;
         if (max_wait[i] > WAIT_BOUND) begin
            n_errors++;
            $display("FAIL random_starvation[%0d]: got max wait %0d cycles, required at most %0d",
                     i, max_wait[i], WAIT_BOUND);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_alternate();
      test_handover();
      test_async_reset();
      test_hold_no_waiter();
`ifdef MUX_ARB_TIMEOUT_EN
      test_timeout();
`else
      test_hold_contended();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
